// File: rtl/cheri_id_ex_reg.sv
// ID->EX pipeline register and issue sequencer for CHERI operations.
// It holds one decoded op, sequences multicycle phases, flags illegal ops and counts issued ops.
module cheri_id_ex_reg #(
    parameter int McCycles      = 2,
    parameter int CntW          = 16,
    parameter int OpdW          = 16,
    parameter int OpCIncAddrImm = 0,
    parameter int OpCSetBounds  = 1,
    parameter int OpCJal        = 2,
    parameter int OpCAuipcc     = 3,
    parameter int OpCAuicgp     = 4,
    parameter int OpCCsrRw      = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic            instr_is_cheri_i,
    input  logic            instr_is_legal_i,
    input  logic [OpdW-1:0] operator_i,
    input  logic [11:0]     imm12_i,
    input  logic [19:0]     imm20_i,
    input  logic [20:0]     imm21_i,
    input  logic [4:0]      cs2_dec_i,
    input  logic            rf_we_i,
    input  logic            multicycle_dec_i,
    input  logic            flush_i,
    input  logic            ex_ready_i,
    output logic            ex_valid_o,
    output logic [OpdW-1:0] ex_operator_o,
    output logic [31:0]     ex_imm_o,
    output logic [4:0]      ex_cs2_o,
    output logic            ex_rf_we_o,
    output logic [1:0]      ex_phase_o,
    output logic            ex_last_o,
    output logic            illegal_o,
    output logic [CntW-1:0] issue_cnt_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StMcyc = 2'd2
    } state_e;

    localparam logic [1:0] LastPhase = 2'(McCycles - 1);

    state_e            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [OpdW-1:0]   op_q, op_d;
    logic [31:0]       imm_q, imm_d;
    logic [4:0]        cs2_q, cs2_d;
    logic              we_q, we_d;
    logic              illegal_q, illegal_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              valid_s;
    logic              last_s;
    logic              consume_s;
    logic              ready_s;
    logic              accept_s;
    logic [31:0]       imm_sel_s;

    // Handshake terms shared by the next-state logic and the ports.
    always_comb begin
        valid_s   = (state_q != StIdle);
        last_s    = (state_q == StHold) || ((state_q == StMcyc) && (phase_q == LastPhase));
        consume_s = valid_s && last_s && ex_ready_i;
        ready_s   = (state_q == StIdle) || consume_s;
        accept_s  = id_valid_i && instr_is_cheri_i && instr_is_legal_i && ready_s && !flush_i;
        illegal_d = id_valid_i && instr_is_cheri_i && !instr_is_legal_i && ready_s && !flush_i;
    end

    // Immediate selection: jump offset first, then upper immediates, else I/S form.
    always_comb begin
        if (operator_i[OpCJal]) begin
            imm_sel_s = {{11{imm21_i[20]}}, imm21_i};
        end else if (operator_i[OpCAuipcc] || operator_i[OpCAuicgp]) begin
            imm_sel_s = {imm20_i, 12'h000};
        end else begin
            imm_sel_s = {{20{imm12_i[11]}}, imm12_i};
        end
    end

    // Next-state, phase, captured fields and issue counter.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        op_d    = op_q;
        imm_d   = imm_q;
        cs2_d   = cs2_q;
        we_d    = we_q;
        cnt_d   = cnt_q;

        // Flush wins over everything, including the count of a consuming op.
        if (flush_i) begin
            state_d = StIdle;
            phase_d = 2'd0;
        end else begin
            if (consume_s && (cnt_q != {CntW{1'b1}})) begin
                cnt_d = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end

            if (accept_s) begin
                state_d = multicycle_dec_i ? StMcyc : StHold;
                phase_d = 2'd0;
                op_d    = operator_i;
                imm_d   = imm_sel_s;
                cs2_d   = operator_i[OpCCsrRw] ? cs2_dec_i : 5'd0;
                we_d    = rf_we_i;
            end else if (consume_s) begin
                state_d = StIdle;
                phase_d = 2'd0;
            end else if ((state_q == StMcyc) && ex_ready_i && !last_s) begin
                phase_d = phase_q + 2'd1;
            end else begin
                phase_d = phase_q;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            phase_q   <= 2'd0;
            op_q      <= '0;
            imm_q     <= 32'd0;
            cs2_q     <= 5'd0;
            we_q      <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            op_q      <= op_d;
            imm_q     <= imm_d;
            cs2_q     <= cs2_d;
            we_q      <= we_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign id_ready_o    = ready_s;
    assign ex_valid_o    = valid_s;
    assign ex_last_o     = last_s;
    assign ex_phase_o    = phase_q;
    assign ex_operator_o = op_q;
    assign ex_imm_o      = imm_q;
    assign ex_cs2_o      = cs2_q;
    assign ex_rf_we_o    = we_q;
    assign illegal_o     = illegal_q;
    assign issue_cnt_o   = cnt_q;

endmodule

// File: tb/tb_cheri_id_ex_reg.sv
// Directed-vector bench for cheri_id_ex_reg (McCycles=2, CntW=4).
module tb_cheri_id_ex_reg;

    localparam int OpdW = 16;
    localparam int CntW = 4;
    localparam logic [15:0] OP_CINC  = 16'h0001;
    localparam logic [15:0] OP_CSETB = 16'h0002;
    localparam logic [15:0] OP_CJAL  = 16'h0004;
    localparam logic [15:0] OP_AUIPC = 16'h0008;
    localparam logic [15:0] OP_CCSR  = 16'h0020;

    logic            clk_s = 1'b0;
    logic            rst_n_s;
    logic            id_valid_s, id_ready_s, cheri_s, legal_s;
    logic [OpdW-1:0] op_s;
    logic [11:0]     imm12_s;
    logic [19:0]     imm20_s;
    logic [20:0]     imm21_s;
    logic [4:0]      cs2_s;
    logic            we_s, mc_s, flush_s, ex_ready_s;
    logic            ex_valid_s, ex_we_s, ex_last_s, illegal_s;
    logic [OpdW-1:0] ex_op_s;
    logic [31:0]     ex_imm_s;
    logic [4:0]      ex_cs2_s;
    logic [1:0]      ex_phase_s;
    logic [CntW-1:0] cnt_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_s = ~clk_s;

    cheri_id_ex_reg #(.McCycles(2), .CntW(CntW), .OpdW(OpdW)) dut (
        .clk_i(clk_s), .rst_ni(rst_n_s),
        .id_valid_i(id_valid_s), .id_ready_o(id_ready_s),
        .instr_is_cheri_i(cheri_s), .instr_is_legal_i(legal_s),
        .operator_i(op_s), .imm12_i(imm12_s), .imm20_i(imm20_s), .imm21_i(imm21_s),
        .cs2_dec_i(cs2_s), .rf_we_i(we_s), .multicycle_dec_i(mc_s),
        .flush_i(flush_s), .ex_ready_i(ex_ready_s),
        .ex_valid_o(ex_valid_s), .ex_operator_o(ex_op_s), .ex_imm_o(ex_imm_s),
        .ex_cs2_o(ex_cs2_s), .ex_rf_we_o(ex_we_s), .ex_phase_o(ex_phase_s),
        .ex_last_o(ex_last_s), .illegal_o(illegal_s), .issue_cnt_o(cnt_s)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; leave time 1 unit after the edge.
    task automatic step();
        @(posedge clk_s);
        #1;
    endtask

    task automatic drive(input logic [15:0] op, input logic [11:0] i12, input logic [19:0] i20,
                         input logic [20:0] i21, input logic [4:0] c2, input logic mc);
        id_valid_s = 1'b1; cheri_s = 1'b1; legal_s = 1'b1;
        op_s = op; imm12_s = i12; imm20_s = i20; imm21_s = i21; cs2_s = c2;
        we_s = 1'b1; mc_s = mc;
    endtask

    initial begin
        rst_n_s = 1'b0; id_valid_s = 1'b0; cheri_s = 1'b0; legal_s = 1'b0;
        op_s = 16'h0000; imm12_s = 12'h000; imm20_s = 20'h00000; imm21_s = 21'h000000;
        cs2_s = 5'd0; we_s = 1'b0; mc_s = 1'b0; flush_s = 1'b0; ex_ready_s = 1'b0;
        #12;
        chk_eq("rst_valid", 32'(ex_valid_s), 32'd0);
        chk_eq("rst_imm",   ex_imm_s,        32'd0);
        chk_eq("rst_op",    32'(ex_op_s),    32'd0);
        chk_eq("rst_cnt",   32'(cnt_s),      32'd0);
        chk_eq("rst_ill",   32'(illegal_s),  32'd0);
        chk_eq("rst_ready", 32'(id_ready_s), 32'd1);
        rst_n_s = 1'b1;
        step();

        // single-cycle op with all-ones imm12
        drive(OP_CINC, 12'hFFF, 20'h0, 21'h0, 5'd7, 1'b0);
        ex_ready_s = 1'b1;
        step();
        id_valid_s = 1'b0;
        #1;
        chk_eq("t1_valid", 32'(ex_valid_s), 32'd1);
        chk_eq("t1_last",  32'(ex_last_s),  32'd1);
        chk_eq("t1_imm",   ex_imm_s,        32'hFFFF_FFFF);
        chk_eq("t1_op",    32'(ex_op_s),    32'h0001);
        chk_eq("t1_cs2",   32'(ex_cs2_s),   32'd0);
        chk_eq("t1_ready", 32'(id_ready_s), 32'd1);
        step();
        chk_eq("t1_cnt",   32'(cnt_s),      32'd1);
        chk_eq("t1_idle",  32'(ex_valid_s), 32'd0);

        // multicycle op: two phases
        drive(OP_CSETB, 12'h010, 20'h0, 21'h0, 5'd0, 1'b1);
        step();
        id_valid_s = 1'b0;
        #1;
        chk_eq("t2_ph0",    32'(ex_phase_s), 32'd0);
        chk_eq("t2_last0",  32'(ex_last_s),  32'd0);
        chk_eq("t2_rdy0",   32'(id_ready_s), 32'd0);
        chk_eq("t2_imm",    ex_imm_s,        32'h0000_0010);
        step();
        chk_eq("t2_ph1",    32'(ex_phase_s), 32'd1);
        chk_eq("t2_last1",  32'(ex_last_s),  32'd1);
        chk_eq("t2_rdy1",   32'(id_ready_s), 32'd1);
        step();
        chk_eq("t2_cnt",    32'(cnt_s),      32'd2);
        chk_eq("t2_idle",   32'(ex_valid_s), 32'd0);

        // back-to-back A,B,C with ex_ready 1,0,1
        drive(OP_CINC, 12'h001, 20'h0, 21'h0, 5'd0, 1'b0);
        step();
        drive(OP_CINC, 12'h002, 20'h0, 21'h0, 5'd0, 1'b0);
        #1;
        chk_eq("t3_a_imm", ex_imm_s, 32'd1);
        chk_eq("t3_a_rdy", 32'(id_ready_s), 32'd1);
        step();
        ex_ready_s = 1'b0;
        drive(OP_CINC, 12'h003, 20'h0, 21'h0, 5'd0, 1'b0);
        #1;
        chk_eq("t3_b_imm",   ex_imm_s,        32'd2);
        chk_eq("t3_stall_r", 32'(id_ready_s), 32'd0);
        chk_eq("t3_cnt_b",   32'(cnt_s),      32'd3);
        step();
        chk_eq("t3_hold_imm", ex_imm_s,        32'd2);
        chk_eq("t3_hold_v",   32'(ex_valid_s), 32'd1);
        chk_eq("t3_hold_cnt", 32'(cnt_s),      32'd3);
        ex_ready_s = 1'b1;
        step();
        id_valid_s = 1'b0;
        chk_eq("t3_c_imm", ex_imm_s,    32'd3);
        chk_eq("t3_c_cnt", 32'(cnt_s),  32'd4);
        step();
        chk_eq("t3_cnt",  32'(cnt_s),      32'd5);
        chk_eq("t3_idle", 32'(ex_valid_s), 32'd0);

        // flush in MCYC phase 0 drops the incoming op
        drive(OP_CSETB, 12'h020, 20'h0, 21'h0, 5'd0, 1'b1);
        step();
        drive(OP_CINC, 12'h030, 20'h0, 21'h0, 5'd0, 1'b0);
        flush_s = 1'b1;
        step();
        flush_s = 1'b0;
        id_valid_s = 1'b0;
        chk_eq("t4_idle", 32'(ex_valid_s), 32'd0);
        chk_eq("t4_cnt",  32'(cnt_s),      32'd5);
        step();
        chk_eq("t4_drop", 32'(ex_valid_s), 32'd0);
        // flush on a consume cycle: no count
        drive(OP_CINC, 12'h040, 20'h0, 21'h0, 5'd0, 1'b0);
        step();
        id_valid_s = 1'b0;
        flush_s = 1'b1;
        step();
        flush_s = 1'b0;
        chk_eq("t4_fc_v",   32'(ex_valid_s), 32'd0);
        chk_eq("t4_fc_cnt", 32'(cnt_s),      32'd5);

        // illegal CHERI op and non-CHERI slot
        id_valid_s = 1'b1; cheri_s = 1'b1; legal_s = 1'b0;
        step();
        id_valid_s = 1'b0;
        chk_eq("t5_ill",   32'(illegal_s),  32'd1);
        chk_eq("t5_valid", 32'(ex_valid_s), 32'd0);
        step();
        chk_eq("t5_ill_end", 32'(illegal_s), 32'd0);
        id_valid_s = 1'b1; cheri_s = 1'b0; legal_s = 1'b1;
        step();
        id_valid_s = 1'b0;
        chk_eq("t5_nc_v",   32'(ex_valid_s), 32'd0);
        chk_eq("t5_nc_ill", 32'(illegal_s),  32'd0);

        // immediate forms and cs2 capture
        drive(OP_CJAL, 12'h000, 20'h0, 21'h1FFFFE, 5'd3, 1'b0);
        step();
        id_valid_s = 1'b0;
        chk_eq("t6_jal", ex_imm_s, 32'hFFFF_FFFE);
        step();
        drive(OP_AUIPC, 12'hFFF, 20'h12345, 21'h0, 5'd3, 1'b0);
        step();
        id_valid_s = 1'b0;
        chk_eq("t6_auipc", ex_imm_s, 32'h1234_5000);
        step();
        drive(OP_CCSR, 12'h7FF, 20'h0, 21'h0, 5'h1C, 1'b0);
        step();
        id_valid_s = 1'b0;
        chk_eq("t6_csr_imm", ex_imm_s,       32'h0000_07FF);
        chk_eq("t6_cs2",     32'(ex_cs2_s),  32'h1C);
        chk_eq("t6_we",      32'(ex_we_s),   32'd1);
        step();
        chk_eq("t6_cnt8", 32'(cnt_s), 32'd8);

        // 17 back-to-back ops saturate the 4-bit counter
        drive(OP_CINC, 12'h005, 20'h0, 21'h0, 5'd0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            step();
        end
        id_valid_s = 1'b0;
        step();
        chk_eq("t6_sat", 32'(cnt_s), 32'hF);

        // async reset in the middle of a multicycle op
        drive(OP_CSETB, 12'h001, 20'h0, 21'h0, 5'd0, 1'b1);
        step();
        id_valid_s = 1'b0;
        #2;
        rst_n_s = 1'b0;
        #1;
        chk_eq("t7_rst_v",   32'(ex_valid_s), 32'd0);
        chk_eq("t7_rst_cnt", 32'(cnt_s),      32'd0);
        rst_n_s = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
